// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared FSM state encoding and word-offset constant for the MEM-stage access controller
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WORD_OFS = 2;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory request/ack controller with pipeline stall; DMEM_ALIGN_CHECK_EN enables misaligned-access trapping
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ALUres_MEM,
    input  logic [31:0]       MemWd_MEM,
    input  logic              MemWrite_MEM,
    input  logic              load_MEM,
    output logic              mem_stall,
    output logic [31:0]       rdata_MEM,
    output logic              addr_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata
);

    state_t state, next_state;
    logic   op;
    logic   misaligned;
    logic   issue;

    assign op        = load_MEM | MemWrite_MEM;
    assign mem_stall = op & (state != DONE);
    assign issue     = (state == IDLE) & op & ~misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |ALUres_MEM[WORD_OFS-1:0];
    // misaligned flag is raised only for the DONE cycle that follows the trapped access
    always_ff @(posedge clk) begin
        if (rst)
            addr_err <= 1'b0;
        else
            addr_err <= (state == IDLE) & op & misaligned;
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, ALUres_MEM[WORD_OFS-1:0]};
    assign misaligned      = 1'b0;
    assign addr_err        = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next_state;
    end

    // next-state: one outstanding transaction, DONE always lasts exactly one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = op ? (misaligned ? DONE : BUSY) : IDLE;
            BUSY:    next_state = dm_ack ? DONE : BUSY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // memory port payload and load-data capture; payload is held untouched outside a new issue
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            rdata_MEM <= '0;
        end else begin
            if (issue) begin
                dm_req   <= 1'b1;
                dm_we    <= MemWrite_MEM;
                dm_addr  <= {ALUres_MEM[ADDR_W-1:WORD_OFS], {WORD_OFS{1'b0}}};
                dm_wdata <= MemWd_MEM;
            end
            if ((state == BUSY) && dm_ack) begin
                dm_req <= 1'b0;
                if (!dm_we)
                    rdata_MEM <= dm_rdata;
            end
            if ((state == IDLE) && op && misaligned)
                rdata_MEM <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUres_MEM;
    logic [31:0] MemWd_MEM;
    logic        MemWrite_MEM;
    logic        load_MEM;
    logic        mem_stall;
    logic [31:0] rdata_MEM;
    logic        addr_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ALUres_MEM(ALUres_MEM), .MemWd_MEM(MemWd_MEM),
        .MemWrite_MEM(MemWrite_MEM), .load_MEM(load_MEM), .mem_stall(mem_stall),
        .rdata_MEM(rdata_MEM), .addr_err(addr_err), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; ALUres_MEM = '0; MemWd_MEM = '0; MemWrite_MEM = 1'b0;
        load_MEM = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        tick; tick;
        rst = 1'b0;
        settle;
        chk("rst_req", {31'd0, dm_req}, 0);
        chk("rst_we", {31'd0, dm_we}, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_rdata", rdata_MEM, 0);
        chk("rst_err", {31'd0, addr_err}, 0);
        chk("rst_stall", {31'd0, mem_stall}, 0);

        // load at 0x10, ack in cycle 1
        tick; load_MEM = 1'b1; ALUres_MEM = 32'h10; settle;
        chk("ld_c0_stall", {31'd0, mem_stall}, 1);
        chk("ld_c0_req", {31'd0, dm_req}, 0);
        tick; dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF; settle;
        chk("ld_c1_req", {31'd0, dm_req}, 1);
        chk("ld_c1_addr", dm_addr, 32'h10);
        chk("ld_c1_we", {31'd0, dm_we}, 0);
        chk("ld_c1_stall", {31'd0, mem_stall}, 1);
        tick; dm_ack = 1'b0; dm_rdata = '0; settle;
        chk("ld_c2_stall", {31'd0, mem_stall}, 0);
        chk("ld_c2_req", {31'd0, dm_req}, 0);
        chk("ld_c2_rdata", rdata_MEM, 32'hDEAD_BEEF);
        chk("ld_c2_err", {31'd0, addr_err}, 0);

        // store 0x12345678 at 0x20, ack delayed to cycle 4
        tick; load_MEM = 1'b0; MemWrite_MEM = 1'b1; ALUres_MEM = 32'h20; MemWd_MEM = 32'h1234_5678; settle;
        chk("st_c0_stall", {31'd0, mem_stall}, 1);
        chk("st_c0_req", {31'd0, dm_req}, 0);
        for (int k = 1; k <= 4; k++) begin
            tick; dm_ack = (k == 4); settle;
            chk("st_busy_req", {31'd0, dm_req}, 1);
            chk("st_busy_we", {31'd0, dm_we}, 1);
            chk("st_busy_addr", dm_addr, 32'h20);
            chk("st_busy_wdata", dm_wdata, 32'h1234_5678);
            chk("st_busy_stall", {31'd0, mem_stall}, 1);
        end
        tick; dm_ack = 1'b0; settle;
        chk("st_done_stall", {31'd0, mem_stall}, 0);
        chk("st_done_req", {31'd0, dm_req}, 0);
        chk("st_done_rdata", rdata_MEM, 32'hDEAD_BEEF);

        // load at 0x30 immediately followed by store at 0x34
        tick; MemWrite_MEM = 1'b0; load_MEM = 1'b1; ALUres_MEM = 32'h30; settle;
        chk("b2b_c0_stall", {31'd0, mem_stall}, 1);
        tick; dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D; settle;
        chk("b2b_c1_req", {31'd0, dm_req}, 1);
        chk("b2b_c1_addr", dm_addr, 32'h30);
        chk("b2b_c1_we", {31'd0, dm_we}, 0);
        tick; dm_ack = 1'b0; dm_rdata = '0; settle;
        chk("b2b_c2_stall", {31'd0, mem_stall}, 0);
        chk("b2b_c2_rdata", rdata_MEM, 32'hCAFE_F00D);
        tick; load_MEM = 1'b0; MemWrite_MEM = 1'b1; ALUres_MEM = 32'h34; MemWd_MEM = 32'hA5A5_A5A5; settle;
        chk("b2b_c3_req", {31'd0, dm_req}, 0);
        chk("b2b_c3_stall", {31'd0, mem_stall}, 1);
        tick; dm_ack = 1'b1; settle;
        chk("b2b_c4_req", {31'd0, dm_req}, 1);
        chk("b2b_c4_we", {31'd0, dm_we}, 1);
        chk("b2b_c4_addr", dm_addr, 32'h34);
        chk("b2b_c4_wdata", dm_wdata, 32'hA5A5_A5A5);
        tick; dm_ack = 1'b0; settle;
        chk("b2b_c5_stall", {31'd0, mem_stall}, 0);
        chk("b2b_c5_req", {31'd0, dm_req}, 0);
        chk("b2b_c5_rdata", rdata_MEM, 32'hCAFE_F00D);

        // misaligned load at 0x13
        tick; MemWrite_MEM = 1'b0; load_MEM = 1'b1; ALUres_MEM = 32'h13; settle;
        chk("mis_c0_stall", {31'd0, mem_stall}, 1);
`ifdef DMEM_ALIGN_CHECK_EN
        tick; settle;
        chk("mis_done_req", {31'd0, dm_req}, 0);
        chk("mis_done_stall", {31'd0, mem_stall}, 0);
        chk("mis_done_err", {31'd0, addr_err}, 1);
        chk("mis_done_rdata", rdata_MEM, 32'h0);
        tick; load_MEM = 1'b0; settle;
        chk("mis_idle_err", {31'd0, addr_err}, 0);
        chk("mis_idle_req", {31'd0, dm_req}, 0);
`else
        tick; dm_ack = 1'b1; dm_rdata = 32'h1111_2222; settle;
        chk("mis_c1_req", {31'd0, dm_req}, 1);
        chk("mis_c1_addr", dm_addr, 32'h10);
        tick; dm_ack = 1'b0; settle;
        chk("mis_done_err", {31'd0, addr_err}, 0);
        chk("mis_done_rdata", rdata_MEM, 32'h1111_2222);
        tick; load_MEM = 1'b0; settle;
`endif

        // reset during BUSY, then a late ack
        load_MEM = 1'b1; ALUres_MEM = 32'h40; settle;
        tick; settle;
        chk("rb_busy_req", {31'd0, dm_req}, 1);
        rst = 1'b1;
        tick; rst = 1'b0; load_MEM = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h5555_AAAA; settle;
        chk("rb_req", {31'd0, dm_req}, 0);
        chk("rb_stall", {31'd0, mem_stall}, 0);
        chk("rb_rdata", rdata_MEM, 32'h0);
        tick; dm_ack = 1'b0; settle;
        chk("rb_late_req", {31'd0, dm_req}, 0);
        chk("rb_late_rdata", rdata_MEM, 32'h0);

        // non-memory instruction stream
        for (int k = 0; k < 6; k++) begin
            tick; ALUres_MEM = $urandom; MemWd_MEM = $urandom; dm_ack = k[0]; settle;
            chk("nm_stall", {31'd0, mem_stall}, 0);
            chk("nm_req", {31'd0, dm_req}, 0);
            chk("nm_addr", dm_addr, 32'h0);
        end
        dm_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage data-memory access controller for the five-stage MIPS pipeline. It consumes the MEM-stage fields (ALUres_MEM, MemWd_MEM, MemWrite_MEM, load_MEM) and turns each load or store into one request/acknowledge transaction on a variable-latency data-memory port. It drives mem_stall to hold the upstream pipeline registers while a transaction is outstanding, and returns load data to the MEM/WB boundary.

## Interface
- ADDR_W, 32, data-memory byte-address width
- clk  input  1  pipeline clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- ALUres_MEM  input  32  effective byte address; low ADDR_W bits used
- MemWd_MEM  input  32  store data
- MemWrite_MEM  input  1  store in MEM stage
- load_MEM  input  1  load in MEM stage
- mem_stall  output  1  hold PC/IFID/IDEX/EXMEM; combinational
- rdata_MEM  output  32  load data, valid while state is DONE
- addr_err  output  1  misaligned access flag, valid while state is DONE
- dm_req  output  1  registered request to data memory
- dm_we  output  1  1 = write, 0 = read; registered
- dm_addr  output  ADDR_W  word-aligned address; registered
- dm_wdata  output  32  write data; registered
- dm_ack  input  1  memory completion, single-cycle pulse
- dm_rdata  input  32  read data, valid with dm_ack

## Operation
- op = load_MEM | MemWrite_MEM. If both are high, the access is a store.
- States: IDLE, BUSY, DONE.
- IDLE, op = 0: remain in IDLE.
- IDLE, op = 1: register dm_req = 1, dm_we = MemWrite_MEM, dm_addr = {ALUres_MEM[ADDR_W-1:2], 2'b00}, dm_wdata = MemWd_MEM; go to BUSY.
- BUSY: hold dm_req and the payload stable until dm_ack.
  - On dm_ack: dm_req <= 0; if the access is a load, rdata_MEM <= dm_rdata; go to DONE.
- DONE: unconditionally return to IDLE next cycle. The pipeline advances at the end of DONE.
- mem_stall = op & (state != DONE).
- dm_ack in IDLE or DONE is ignored.
- The controller supports only one outstanding transaction.
- The controller handles word accesses only. Byte and half-word accesses are outside this block.
- rdata_MEM holds its value until the next load completes. Stores leave it unchanged.

## Timing
- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, rdata_MEM 0, addr_err 0. mem_stall follows its equation, so it is 0 while op = 0.
- Cycle-level sequence (op enters MEM at cycle 0):
  - dm_req is high from cycle 1.
  - The earliest dm_ack is at cycle 1, which gives DONE at cycle 2.
  - mem_stall is high in cycles 0–1 and low in cycle 2.
  - Minimum MEM residency is 3 cycles. Each extra wait cycle adds 1.
- Back-to-back memory ops: the next op appears in IDLE the cycle after DONE. No gap cycle is needed beyond the DONE state.
- rst mid-transaction (BUSY): next cycle the state is IDLE and dm_req is 0. The abandoned transaction is dropped. A late dm_ack is ignored.
- Non-memory instructions never stall and never touch the dm_* outputs.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - IDLE with op and ALUres_MEM[1:0] != 0: no request is issued; the next state is DONE.
  - In DONE, addr_err = 1 and rdata_MEM = 0.
  - mem_stall is high for 1 cycle.
- DMEM_ALIGN_CHECK_EN undefined:
  - Low address bits are silently dropped.
  - addr_err is tied to 0.
  - The port remains present.

## Structure
- The shared package holds:
  - the state typedef (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10);
  - the word-offset constant (2).
- No sub-module. The block is one FSM plus its output registers.

## Test plan
- Reset, then a load at 0x0000_0010 with dm_ack in cycle 1 and dm_rdata = 0xDEAD_BEEF:
  - dm_addr = 0x10 and dm_we = 0;
  - mem_stall is high for 2 cycles;
  - rdata_MEM = 0xDEAD_BEEF in DONE.
- Store of 0x1234_5678 at 0x20 with dm_ack delayed 4 cycles:
  - dm_req is held high for 4 cycles with stable dm_we = 1, dm_addr = 0x20, dm_wdata = 0x1234_5678;
  - mem_stall is high for 5 cycles;
  - rdata_MEM is unchanged.
- Load followed immediately by a store:
  - two distinct requests are issued, with DONE → IDLE → BUSY between them;
  - no request is dropped or merged.
- rst asserted during BUSY, then dm_ack arrives one cycle later:
  - state is IDLE, dm_req = 0, and the ack is ignored.
- A non-memory instruction stream: mem_stall and dm_req stay 0 throughout.
- With DMEM_ALIGN_CHECK_EN, a load at 0x0000_0013:
  - no dm_req is issued;
  - addr_err = 1 for one cycle and rdata_MEM = 0.
- Without DMEM_ALIGN_CHECK_EN, the same load issues dm_addr = 0x10.
